// File: rtl/count_sweep_ctrl.sv
// Sequencer that steers an up/down counter through N triangle sweeps between
// latched Low/High bounds, with start/stop handshake and status pulses.
module count_sweep_ctrl #(
    parameter int BITS  = 4,
    parameter int CYC_W = 4
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             Start_i,
    input  logic             Stop_i,
    input  logic [BITS-1:0]  Low_i,
    input  logic [BITS-1:0]  High_i,
    input  logic [CYC_W-1:0] Cycles_i,
    input  logic [BITS-1:0]  Count_i,
    output logic             CntUp_o,
    output logic             CntDown_o,
    output logic             CntEnable_o,
    output logic             Busy_o,
    output logic             Done_o,
    output logic             Aborted_o,
    output logic             Error_o,
    output logic [CYC_W-1:0] CyclesLeft_o
);

    typedef enum logic [2:0] {IDLE, SEEK, RISE, FALL, DONE} state_t;

    state_t           state_q, state_d;
    logic [BITS-1:0]  low_q, low_d;
    logic [BITS-1:0]  high_q, high_d;
    logic [CYC_W-1:0] cyclesLeft_q, cyclesLeft_d;
    logic             done_q, aborted_q, error_q;

    logic active, abort, startOk, accept, reject;
    logic belowLow, aboveLow, belowHigh, sweepEnd;

    assign active    = (state_q == SEEK) || (state_q == RISE) || (state_q == FALL);
    assign abort     = Stop_i && active;
    assign startOk   = (Low_i < High_i) && (Cycles_i != '0);
    assign accept    = (state_q == IDLE) && Start_i && startOk;
    assign reject    = (state_q == IDLE) && Start_i && !startOk;
    assign belowLow  = Count_i < low_q;
    assign aboveLow  = Count_i > low_q;
    assign belowHigh = Count_i < high_q;
    assign sweepEnd  = (state_q == FALL) && !aboveLow;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stop overrides every transition out of the active states.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = SEEK;
            SEEK: if (!belowLow && !aboveLow) state_d = RISE;
            RISE: if (!belowHigh) state_d = FALL;
            FALL: if (!aboveLow) state_d = (cyclesLeft_q == CYC_W'(1)) ? DONE : RISE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_comb begin
        CntUp_o   = 1'b0;
        CntDown_o = 1'b0;
        if (!abort) begin
            unique case (state_q)
                SEEK: begin
                    CntUp_o   = belowLow;
                    CntDown_o = aboveLow;
                end
                RISE:    CntUp_o   = belowHigh;
                FALL:    CntDown_o = aboveLow;
                default: ;
            endcase
        end
        CntEnable_o = CntUp_o || CntDown_o;
    end

    always_comb begin
        low_d        = low_q;
        high_d       = high_q;
        cyclesLeft_d = cyclesLeft_q;
        if (accept) begin
            low_d        = Low_i;
            high_d       = High_i;
            cyclesLeft_d = Cycles_i;
        end else if (abort) begin
            cyclesLeft_d = '0;
        end else if (sweepEnd) begin
            cyclesLeft_d = cyclesLeft_q - CYC_W'(1);
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            low_q        <= '0;
            high_q       <= '0;
            cyclesLeft_q <= '0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            low_q        <= low_d;
            high_q       <= high_d;
            cyclesLeft_q <= cyclesLeft_d;
            done_q       <= (state_d == DONE);
            aborted_q    <= abort;
            error_q      <= reject;
        end
    end

    assign Busy_o       = (state_q != IDLE);
    assign Done_o       = done_q;
    assign Aborted_o    = aborted_q;
    assign Error_o      = error_q;
    assign CyclesLeft_o = cyclesLeft_q;

endmodule

// File: tb/tb_count_sweep_ctrl.sv
// Randomized bench for count_sweep_ctrl driving a behavioural up/down counter,
// checked against a per-cycle plan derived from the sweep rules.
module tb_count_sweep_ctrl;

    localparam int BITS  = 4;
    localparam int CYC_W = 4;

    logic             Clock = 1'b0;
    logic             ResetN;
    logic             Start_i, Stop_i;
    logic [BITS-1:0]  Low_i, High_i;
    logic [CYC_W-1:0] Cycles_i;
    logic [BITS-1:0]  cnt;
    logic             CntUp_o, CntDown_o, CntEnable_o;
    logic             Busy_o, Done_o, Aborted_o, Error_o;
    logic [CYC_W-1:0] CyclesLeft_o;

    always #5 Clock = ~Clock;

    count_sweep_ctrl #(.BITS(BITS), .CYC_W(CYC_W)) dut (
        .Clock       (Clock),
        .ResetN      (ResetN),
        .Start_i     (Start_i),
        .Stop_i      (Stop_i),
        .Low_i       (Low_i),
        .High_i      (High_i),
        .Cycles_i    (Cycles_i),
        .Count_i     (cnt),
        .CntUp_o     (CntUp_o),
        .CntDown_o   (CntDown_o),
        .CntEnable_o (CntEnable_o),
        .Busy_o      (Busy_o),
        .Done_o      (Done_o),
        .Aborted_o   (Aborted_o),
        .Error_o     (Error_o),
        .CyclesLeft_o(CyclesLeft_o)
    );

    // Behavioural stand-in for the attached counter.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) cnt <= '0;
        else if (CntEnable_o && CntUp_o) cnt <= cnt + 1'b1;
        else if (CntEnable_o && CntDown_o) cnt <= cnt - 1'b1;
    end

    // flags = {up, down, enable, busy, done, aborted, error}
    typedef struct {
        int         count;
        logic [6:0] flags;
        int         left;
    } entry_t;

    entry_t plan[$];
    int testsRun    = 0;
    int testsFailed = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [6:0] mk(input bit up, input bit dn, input bit en, input bit busy,
                                      input bit done, input bit ab, input bit err);
        return {up, dn, en, busy, done, ab, err};
    endfunction

    task automatic checkCycle(input string tag, input logic [6:0] flags, input int count, input int left);
        checkOutput({tag, " flags"}, {25'b0, CntUp_o, CntDown_o, CntEnable_o, Busy_o, Done_o, Aborted_o, Error_o},
                    {25'b0, flags});
        checkOutput({tag, " count"}, {28'b0, cnt}, 32'(count));
        checkOutput({tag, " left"}, {28'b0, CyclesLeft_o}, 32'(left));
    endtask

    task automatic pushEntry(input int c, input logic [6:0] f, input int left);
        entry_t e;
        e.count = c;
        e.flags = f;
        e.left  = left;
        plan.push_back(e);
    endtask

    // Walk to Low, then N times up to High and back, then one Done cycle.
    task automatic buildPlan(input int c0, input int l, input int h, input int n);
        int c;
        plan.delete();
        c = c0;
        while (c != l) begin
            pushEntry(c, mk(c < l, c > l, 1, 1, 0, 0, 0), n);
            c = (c < l) ? c + 1 : c - 1;
        end
        pushEntry(l, mk(0, 0, 0, 1, 0, 0, 0), n);
        for (int k = 0; k < n; k++) begin
            for (int v = l; v <= h; v++) pushEntry(v, mk(v < h, 0, v < h, 1, 0, 0, 0), n - k);
            for (int v = h; v >= l; v--) pushEntry(v, mk(0, v > l, v > l, 1, 0, 0, 0), n - k);
        end
        pushEntry(l, mk(0, 0, 0, 1, 1, 0, 0), 0);
    endtask

    // mode 0: run to completion, 1: Stop at cycle 'at' (random if negative),
    // 2: async reset at cycle 'at'. noise drives ignored Start/Stop traffic.
    task automatic applyStimulus(input int l, input int h, input int n, input int mode, input int at, input bit noise);
        int c0;
        int stopAt;
        c0 = int'(cnt);
        Start_i  = 1'b1;
        Stop_i   = 1'b0;
        Low_i    = BITS'(l);
        High_i   = BITS'(h);
        Cycles_i = CYC_W'(n);
        @(posedge Clock); #1;
        Start_i = 1'b0;
        Low_i   = BITS'($urandom_range(0, 15));
        High_i  = BITS'($urandom_range(0, 15));
        if (l >= h || n == 0) begin
            @(negedge Clock);
            checkCycle("reject", mk(0, 0, 0, 0, 0, 0, 1), c0, 0);
            @(posedge Clock); #1;
            @(negedge Clock);
            checkCycle("post-reject", 7'b0, c0, 0);
            return;
        end
        buildPlan(c0, l, h, n);
        stopAt = (at < 0) ? int'($urandom_range(0, plan.size() - 2)) : at;
        for (int k = 0; k < plan.size(); k++) begin
            Stop_i  = 1'b0;
            Start_i = 1'b0;
            if (noise) begin
                Start_i  = ($urandom_range(0, 3) == 0) || (k == plan.size() - 1);
                Stop_i   = (k == plan.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                Low_i    = BITS'($urandom_range(0, 7));
                High_i   = BITS'($urandom_range(8, 15));
                Cycles_i = CYC_W'($urandom_range(1, 15));
            end
            if (mode == 1 && k == stopAt) begin
                Stop_i = 1'b1;
                @(negedge Clock);
                checkCycle("stop", plan[k].flags & 7'b0001111, plan[k].count, plan[k].left);
                @(posedge Clock); #1;
                Stop_i  = 1'b0;
                Start_i = 1'b0;
                @(negedge Clock);
                checkCycle("aborted", mk(0, 0, 0, 0, 0, 1, 0), plan[k].count, 0);
                return;
            end
            if (mode == 2 && k == stopAt) begin
                #2 ResetN = 1'b0;
                #1 checkCycle("async reset", 7'b0, 0, 0);
                Start_i = 1'b0;
                Stop_i  = 1'b0;
                @(posedge Clock);
                @(negedge Clock);
                checkCycle("held reset", 7'b0, 0, 0);
                ResetN = 1'b1;
                @(posedge Clock); #1;
                return;
            end
            @(negedge Clock);
            checkCycle("seq", plan[k].flags, plan[k].count, plan[k].left);
            @(posedge Clock); #1;
        end
        Start_i = 1'b0;
        Stop_i  = 1'b0;
        @(negedge Clock);
        checkCycle("idle", 7'b0, l, 0);
    endtask

    initial begin
        int l, h, n, mode, at;
        ResetN   = 1'b0;
        Start_i  = 1'b0;
        Stop_i   = 1'b0;
        Low_i    = '0;
        High_i   = '0;
        Cycles_i = '0;
        #2 checkCycle("reset", 7'b0, 0, 0);
        repeat (2) @(posedge Clock);
        @(negedge Clock) ResetN = 1'b1;
        @(posedge Clock); #1;

        applyStimulus(2, 5, 1, 0, 0, 0);

        at = ((int'(cnt) > 1) ? int'(cnt) - 1 : 1 - int'(cnt)) + 1 + 6 + 2;
        applyStimulus(1, 6, 2, 2, at, 0);

        applyStimulus(0, 15, 3, 0, 0, 0);

        applyStimulus(7, 7, 2, 0, 0, 0);
        applyStimulus(3, 9, 0, 0, 0, 0);

        at = ((int'(cnt) > 2) ? int'(cnt) - 2 : 2 - int'(cnt)) + 1 + 2;
        applyStimulus(2, 9, 2, 1, at, 0);

        applyStimulus(3, 8, 2, 0, 0, 1);
        applyStimulus(1, 4, 1, 0, 0, 1);

        repeat (40) begin
            l = int'($urandom_range(0, 15));
            h = int'($urandom_range(0, 15));
            n = int'($urandom_range(0, 4));
            if ($urandom_range(0, 3) != 0) begin
                if (l > h) begin
                    int t;
                    t = l; l = h; h = t;
                end
                if (l == h) begin
                    if (h < 15) h++;
                    else l--;
                end
                if (n == 0) n = 1;
            end
            mode = ($urandom_range(0, 2) == 0) ? 1 : 0;
            applyStimulus(l, h, n, mode, -1, 1);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/count_sweep_ctrl.md
# count_sweep_ctrl

Sequencer for the team's parameterized up/down counter. Drives the counter's Up/Down/Enable pins to produce N triangle sweeps between programmable Low and High bounds, with a start/stop handshake and completion/abort/error pulses. Sits between a register-interface/control FSM and one counter instance, and reads the counter's Count output back.

## Interface
- BITS, 4, counter width; must equal the attached counter's width.
- CYC_W, 4, width of the sweep-count field.

- Clock  in  1  rising-edge clock, shared with the counter.
- ResetN  in  1  asynchronous, active-low reset.
- Start  in  1  request a sequence; sampled only in IDLE.
- Stop  in  1  abort the active sequence.
- Low  in  BITS  lower sweep bound, unsigned; latched at Start acceptance.
- High  in  BITS  upper sweep bound, unsigned; latched at Start acceptance.
- Cycles  in  CYC_W  number of triangle sweeps; latched at Start acceptance.
- Count  in  BITS  counter value feedback.
- CntUp  out  1  counter Up pin.
- CntDown  out  1  counter Down pin.
- CntEnable  out  1  counter Enable pin.
- Busy  out  1  high in any state other than IDLE.
- Done  out  1  one-cycle pulse on normal completion.
- Aborted  out  1  one-cycle registered pulse after Stop.
- Error  out  1  one-cycle registered pulse after a rejected Start.
- CyclesLeft  out  CYC_W  remaining sweeps, including the one in progress.

## Operation
- States are IDLE, SEEK, RISE, FALL and DONE.
- Reset value: IDLE, CyclesLeft=0, latched bounds=0, and Busy, Done, Aborted, Error, CntUp, CntDown, CntEnable all 0.
  - CntUp=CntDown=0 during reset, so the counter resets to 0.
- IDLE:
  - Start with Low<High and Cycles≠0: latch Low, High and Cycles; CyclesLeft=Cycles; go to SEEK.
  - Start with Low>=High or Cycles=0: stay in IDLE; Error=1 for the next cycle.
- SEEK:
  - Count<Low: CntUp=1, CntEnable=1.
  - Count>Low: CntDown=1, CntEnable=1.
  - Count=Low: CntEnable=0; go to RISE.
- RISE:
  - Count<High: CntUp=1, CntEnable=1.
  - Count=High: CntEnable=0; go to FALL.
- FALL:
  - Count>Low: CntDown=1, CntEnable=1.
  - Count=Low: CntEnable=0; decrement CyclesLeft; go to DONE if CyclesLeft=1, else back to RISE.
- DONE: Done=1 for this single cycle; return to IDLE.
- Turning points dwell one cycle (no enable) at Low and at High.
- Stop in SEEK, RISE or FALL:
  - CntEnable forced to 0 in the same cycle (combinational).
  - Next state IDLE; Aborted=1 for the next cycle; Done not pulsed; CyclesLeft cleared.
- Stop in IDLE or DONE is ignored. Stop has priority over every transition.
- Start while Busy is ignored. Bound inputs may change freely after acceptance.
- Comparisons are unsigned, full BITS width; no arithmetic on Count.
- High may equal 2^BITS-1. The counter never wraps, because Enable drops at the bound.

## Timing
- CntUp, CntDown and CntEnable are combinational from state, Count and Stop. Busy is decoded from the state register.
- Done, Aborted, Error and CyclesLeft are registered. Done is high exactly during the DONE-state cycle.
- At most one of CntUp/CntDown is high; both are 0 whenever CntEnable=0.
- Cycle numbering: cycle 0 = first cycle after the Start-accept edge. C0 = Count at acceptance, L = Low, H = High, N = Cycles.
  - SEEK lasts |C0-L|+1 cycles.
  - Each RISE and each FALL lasts H-L+1 cycles.
  - Done is high in cycle (|C0-L|+1) + 2·N·(H-L+1).
- Start is accepted in the same cycle that Done is high? No: DONE→IDLE takes one edge, so Start is accepted no earlier than the cycle after Done.
- Reset asserted mid-sequence: immediate return to IDLE, all outputs 0, no Done or Aborted pulse.

## Test plan
- Reset, counter at 0: Low=2, High=5, Cycles=1, pulse Start → Count sequence 0,1,2,2,3,4,5,5,4,3,2, then Done in cycle 11; Busy=1 in cycles 0–11.
- Low=0, High=15 (BITS=4), Cycles=3, counter at 0 → Count never leaves 0..15 (no wrap); CyclesLeft steps 3→2→1; Done in cycle 1+2·3·16=97.
- Start with Low=7, High=7 → Error=1 for one cycle, Busy stays 0, counter Enable never asserted; repeat with Cycles=0 → same result.
- Stop asserted while Count=4 in RISE (Low=2, High=9) → CntEnable=0 in that cycle; Count holds 4; Aborted pulses; IDLE; no Done.
- Second Start during RISE with different bounds → ignored; sweep completes with the original bounds. Start during the Done cycle → ignored; Start in the next cycle → accepted.
- ResetN pulsed low mid-FALL → all outputs 0 asynchronously; counter resets to 0; after release a new Start runs a normal sequence from SEEK.
